// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding-select and load-use/branch stall control for a 5-stage MIPS pipeline.
// Producer tags for EX, MEM and WB are shadowed here; the WB tag doubles as the WB-latch source for sel 3.
module fwd_hazard_ctrl #(
    parameter int AW      = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int CNT_W   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid_i,
    input  logic [NUM_SRC*AW-1:0]  id_src_i,
    input  logic [NUM_SRC-1:0]     id_src_used_i,
    input  logic [AW-1:0]          id_dst_i,
    input  logic                   id_regwrite_i,
    input  logic                   id_memread_i,
    input  logic                   id_is_branch_i,
    input  logic                   flush_i,
    output logic [NUM_SRC*2-1:0]   ex_fwd_sel_o,
    output logic [NUM_SRC*2-1:0]   id_cmp_sel_o,
    output logic                   stall_o,
    output logic [CNT_W-1:0]       stall_cnt_o
);
    typedef struct packed {
        logic          v;
        logic          wr;
        logic          ld;
        logic [AW-1:0] dst;
    } tag_t;

    tag_t                 ex_q, mem_q, wb_q, ex_d;
    logic [NUM_SRC*2-1:0] fwd_q, fwd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 haz, bubble;

    function automatic logic hit(input tag_t t, input int s);
        return t.v && t.wr && t.dst != '0 && t.dst == id_src_i[s*AW +: AW] && id_src_used_i[s];
    endfunction

    always_comb begin
        haz          = 1'b0;
        fwd_d        = '0;
        id_cmp_sel_o = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            haz = haz | (ex_q.ld && hit(ex_q, s))
                      | (id_is_branch_i && (hit(ex_q, s) || (mem_q.ld && hit(mem_q, s))));
            fwd_d[2*s +: 2] = hit(ex_q, s) ? 2'd1 :
                              hit(mem_q, s) ? 2'd2 :
                              (DEPTH == 3 && hit(wb_q, s)) ? 2'd3 : 2'd0;
            id_cmp_sel_o[2*s +: 2] = (hit(mem_q, s) && !mem_q.ld) ? 2'd1 :
                                     hit(wb_q, s) ? 2'd2 : 2'd0;
        end
    end

    assign stall_o      = id_valid_i && !flush_i && haz;
    assign bubble       = stall_o || flush_i || !id_valid_i;
    assign ex_d         = bubble ? '0 : {1'b1, id_regwrite_i, id_memread_i, id_dst_i};
    assign cnt_d        = !stall_o ? '0 : (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign ex_fwd_sel_o = fwd_q;
    assign stall_cnt_o  = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            fwd_q <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            fwd_q <= bubble ? '0 : fwd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: table-driven check of forwarding/stall control, DEPTH=3 and DEPTH=2 side by side.
module tb_fwd_hazard_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       id_valid = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0, id_is_branch = 1'b0, flush = 1'b0;
    logic [9:0] id_src = '0;
    logic [1:0] id_src_used = '0;
    logic [4:0] id_dst = '0;
    logic [3:0] fwd3, cmp3, fwd2, cmp2;
    logic       stall3, stall2;
    logic [2:0] cnt3, cnt2;
    int         n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.DEPTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_src_i(id_src), .id_src_used_i(id_src_used),
        .id_dst_i(id_dst), .id_regwrite_i(id_regwrite), .id_memread_i(id_memread),
        .id_is_branch_i(id_is_branch), .flush_i(flush), .ex_fwd_sel_o(fwd3), .id_cmp_sel_o(cmp3),
        .stall_o(stall3), .stall_cnt_o(cnt3));

    fwd_hazard_ctrl #(.DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_src_i(id_src), .id_src_used_i(id_src_used),
        .id_dst_i(id_dst), .id_regwrite_i(id_regwrite), .id_memread_i(id_memread),
        .id_is_branch_i(id_is_branch), .flush_i(flush), .ex_fwd_sel_o(fwd2), .id_cmp_sel_o(cmp2),
        .stall_o(stall2), .stall_cnt_o(cnt2));

    typedef struct {
        logic       v;
        logic [4:0] rs, rt;
        logic [1:0] used;
        logic [4:0] dst;
        logic       rw, ld, br;
        logic       st;
        logic [3:0] cmp, f3, f2;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [4:0] rs, rt, input logic [1:0] used,
                                input logic [4:0] dst, input logic rw, ld, br, st,
                                input logic [3:0] cmp, f3, f2, input logic [2:0] cnt);
        vec_t r;
        r.v = v; r.rs = rs; r.rt = rt; r.used = used; r.dst = dst; r.rw = rw; r.ld = ld; r.br = br;
        r.st = st; r.cmp = cmp; r.f3 = f3; r.f2 = f2; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change on the falling edge; checks run 1 time unit later, well before the next rising edge.
    task automatic drive(input logic v, input logic [4:0] rs, rt, input logic [1:0] used,
                         input logic [4:0] dst, input logic rw, ld, br, fl);
        @(negedge clk);
        id_valid = v; id_src = {rt, rs}; id_src_used = used; id_dst = dst;
        id_regwrite = rw; id_memread = ld; id_is_branch = br; flush = fl;
        #1;
    endtask

    initial begin
        // Each row is one cycle; f3/f2/cnt are what the registers show for the previous row's edge.
        tbl.push_back(mk(1, 1, 2, 3, 3, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0));      // add $3
        tbl.push_back(mk(1, 3, 5, 3, 4, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0));      // sub $4,$3,$5
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 2, 1, 1, 0, 0, 4'h0, 4'h0, 4'h0, 0));      // lw $2
        tbl.push_back(mk(1, 2, 2, 3, 6, 1, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0));      // add $6,$2,$2
        tbl.push_back(mk(1, 2, 2, 3, 6, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'hA, 4'hA, 0));
        tbl.push_back(mk(1, 1, 0, 1, 7, 1, 1, 0, 0, 4'h0, 4'h0, 4'h0, 0));      // lw $7
        tbl.push_back(mk(1, 7, 0, 3, 0, 0, 0, 1, 1, 4'h0, 4'h0, 4'h0, 0));      // beq $7,$0
        tbl.push_back(mk(1, 7, 0, 3, 0, 0, 0, 1, 1, 4'h0, 4'h0, 4'h0, 1));
        tbl.push_back(mk(1, 7, 0, 3, 0, 0, 0, 1, 0, 4'h2, 4'h0, 4'h0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h3, 4'h0, 0));
        tbl.push_back(mk(1, 1, 2, 3, 8, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0));      // add $8
        tbl.push_back(mk(1, 1, 2, 3, 8, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0));      // or $8
        tbl.push_back(mk(1, 8, 8, 3, 9, 1, 0, 0, 0, 4'h5, 4'h0, 4'h0, 0));      // and $9,$8,$8
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h5, 4'h5, 0));
        tbl.push_back(mk(1, 1, 2, 3, 0, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0));      // add $0
        tbl.push_back(mk(1, 1, 2, 3, 0, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0));      // or $0
        tbl.push_back(mk(1, 0, 0, 3, 9, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0));      // and $9,$0,$0
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0));
        tbl.push_back(mk(1, 1, 2, 3, 10, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0));     // add $10
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0));
        tbl.push_back(mk(1, 10, 1, 3, 11, 1, 0, 0, 0, 4'h2, 4'h0, 4'h0, 0));    // sub $11,$10,$1
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h3, 4'h0, 0));
        tbl.push_back(mk(1, 1, 2, 3, 12, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0));     // add $12
        tbl.push_back(mk(1, 12, 11, 3, 0, 0, 0, 1, 1, 4'h8, 4'h0, 4'h0, 0));    // bne $12,$11
        tbl.push_back(mk(1, 12, 11, 3, 0, 0, 0, 1, 0, 4'h1, 4'h0, 4'h0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h2, 4'h2, 0));

        #12;
        chk("reset fwd", 8'(fwd3), 8'h0);
        chk("reset cnt", 8'(cnt3), 8'h0);
        chk("reset stall", 8'(stall3), 8'h0);
        chk("reset cmp", 8'(cmp3), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].used, tbl[i].dst, tbl[i].rw, tbl[i].ld, tbl[i].br, 1'b0);
            chk($sformatf("row%0d stall", i), 8'(stall3), 8'(tbl[i].st));
            chk($sformatf("row%0d cmp", i), 8'(cmp3), 8'(tbl[i].cmp));
            chk($sformatf("row%0d fwd3", i), 8'(fwd3), 8'(tbl[i].f3));
            chk($sformatf("row%0d fwd2", i), 8'(fwd2), 8'(tbl[i].f2));
            chk($sformatf("row%0d cnt", i), 8'(cnt3), 8'(tbl[i].cnt));
        end

        // Flush overrides a pending load-use stall and must keep the squashed op out of EX.
        drive(1, 1, 0, 2'b01, 13, 1, 1, 0, 0);
        drive(1, 13, 13, 2'b11, 14, 1, 0, 0, 1);
        chk("flush stall", 8'(stall3), 8'h0);
        drive(1, 14, 14, 2'b11, 15, 1, 0, 0, 0);
        chk("post-flush stall", 8'(stall3), 8'h0);
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        chk("post-flush fwd", 8'(fwd3), 8'h0);

        // Asynchronous reset in the middle of a two-cycle load->branch stall.
        drive(1, 1, 0, 2'b01, 16, 1, 1, 0, 0);
        drive(1, 16, 0, 2'b11, 0, 0, 0, 1, 0);
        chk("ldbr stall1", 8'(stall3), 8'h1);
        drive(1, 16, 0, 2'b11, 0, 0, 0, 1, 0);
        chk("ldbr stall2", 8'(stall3), 8'h1);
        chk("ldbr cnt", 8'(cnt3), 8'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst stall", 8'(stall3), 8'h0);
        chk("async rst cnt", 8'(cnt3), 8'h0);
        chk("async rst cmp", 8'(cmp3), 8'h0);
        chk("async rst fwd", 8'(fwd3), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-rst stall", 8'(stall3), 8'h0);
        @(posedge clk);
        #1;
        chk("post-rst cnt", 8'(cnt3), 8'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
